// File: rtl/rv32i_lsu.sv
// RV32I load/store unit: one request at a time in front of a single-port word RAM
// with one cycle of read latency. Stores are lane-replicated, loads are extracted and extended.
module rv32i_lsu #(
    parameter int ADDR_WIDTH = 15
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] d_addr,
    output logic                  d_we,
    output logic [3:0]            d_be,
    output logic [31:0]           d_wdata,
    input  logic [31:0]           d_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    state_t                r_state;
    state_t                w_nextState;
    logic                  r_we;
    logic [2:0]            r_funct3;
    logic [1:0]            r_addrLo;
    logic                  r_rspErr;
    logic [31:0]           r_rspRdata;
    logic [ADDR_WIDTH-1:0] r_dAddr;
    logic                  r_dWe;
    logic [3:0]            r_dBe;
    logic [31:0]           r_dWdata;

    logic                  w_accept;
    logic                  w_misalign;
    logic                  w_badFunct;
    logic                  w_outOfRange;
    logic                  w_reqErr;
    logic [3:0]            w_storeBe;
    logic [31:0]           w_storeData;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [31:0]           w_loadData;

    assign w_accept = req_valid && (r_state == IDLE);

    // Rejection is decided on the raw request so an error never touches the RAM.
    always_comb begin
        w_misalign = 1'b0;
        case (req_funct3[1:0])
            2'b01:   w_misalign = req_addr[0];
            2'b10:   w_misalign = |req_addr[1:0];
            default: w_misalign = 1'b0;
        endcase
        w_badFunct   = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                       (req_funct3 == 3'b111) || (req_we && req_funct3[2]);
        w_outOfRange = (req_addr >> (ADDR_WIDTH + 2)) != 32'd0;
        w_reqErr     = w_misalign || w_badFunct || w_outOfRange;
    end

    always_comb begin
        w_storeBe   = 4'b1111;
        w_storeData = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                w_storeBe   = 4'b0001 << req_addr[1:0];
                w_storeData = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                w_storeBe   = 4'b0011 << {req_addr[1], 1'b0};
                w_storeData = {2{req_wdata[15:0]}};
            end
            default: begin
                w_storeBe   = 4'b1111;
                w_storeData = req_wdata;
            end
        endcase
    end

    always_comb begin
        w_byte = d_rdata[7:0];
        case (r_addrLo)
            2'b00:   w_byte = d_rdata[7:0];
            2'b01:   w_byte = d_rdata[15:8];
            2'b10:   w_byte = d_rdata[23:16];
            default: w_byte = d_rdata[31:24];
        endcase
        w_half = r_addrLo[1] ? d_rdata[31:16] : d_rdata[15:0];
        case (r_funct3)
            3'b000:  w_loadData = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_loadData = {24'd0, w_byte};
            3'b001:  w_loadData = {{16{w_half[15]}}, w_half};
            3'b101:  w_loadData = {16'd0, w_half};
            default: w_loadData = d_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (req_valid) w_nextState = w_reqErr ? RESP : ACCESS;
            ACCESS:  w_nextState = r_we ? RESP : WAIT;
            WAIT:    w_nextState = RESP;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (r_state == IDLE);
        rsp_valid = (r_state == RESP);
        rsp_err   = r_rspErr;
        rsp_rdata = r_rspRdata;
        d_addr    = r_dAddr;
        d_we      = r_dWe;
        d_be      = r_dBe;
        d_wdata   = r_dWdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_we     <= 1'b0;
            r_funct3 <= 3'd0;
            r_addrLo <= 2'd0;
        end else if (w_accept) begin
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            r_addrLo <= req_addr[1:0];
        end
    end

    // RAM strobes live for exactly the ACCESS cycle; address and data hold afterwards.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dAddr  <= '0;
            r_dWe    <= 1'b0;
            r_dBe    <= 4'b0000;
            r_dWdata <= 32'd0;
        end else if (w_accept && !w_reqErr) begin
            r_dAddr <= req_addr[ADDR_WIDTH+1:2];
            r_dWe   <= req_we;
            r_dBe   <= req_we ? w_storeBe : 4'b0000;
            if (req_we) r_dWdata <= w_storeData;
        end else begin
            r_dWe <= 1'b0;
            r_dBe <= 4'b0000;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rspErr   <= 1'b0;
            r_rspRdata <= 32'd0;
        end else begin
            r_rspErr   <= w_accept && w_reqErr;
            r_rspRdata <= (r_state == WAIT) ? w_loadData : 32'd0;
        end
    end

endmodule

// File: tb/tb_rv32i_lsu.sv
// Self-checking bench for rv32i_lsu: directed corner cases plus random traffic
// compared against a byte-addressed memory model.
module tb_rv32i_lsu;

    localparam int AW = 15;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [2:0]    req_funct3;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] d_addr;
    logic          d_we;
    logic [3:0]    d_be;
    logic [31:0]   d_wdata;
    logic [31:0]   d_rdata = 32'd0;

    int checks = 0;
    int errors = 0;
    int weCycles = 0;

    bit [31:0]  ram [0:(1<<AW)-1];
    logic [31:0] ramMerged;
    bit [7:0]   refMem [bit [31:0]];

    rv32i_lsu #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .d_addr(d_addr), .d_we(d_we), .d_be(d_be), .d_wdata(d_wdata), .d_rdata(d_rdata)
    );

    always #5 clk = ~clk;

    // Word RAM with one cycle read latency, byte-enabled writes.
    always @(posedge clk) begin
        ramMerged = ram[d_addr];
        if (d_we) begin
            weCycles++;
            for (int i = 0; i < 4; i++)
                if (d_be[i]) ramMerged[8*i +: 8] = d_wdata[8*i +: 8];
            ram[d_addr] <= ramMerged;
        end
        d_rdata <= ram[d_addr];
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int refSize(input bit [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit refErr(input bit we, input bit [2:0] f3, input bit [31:0] addr);
        int size = refSize(f3);
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
        if (we && f3[2]) return 1'b1;
        if ((addr % size) != 0) return 1'b1;
        if (addr >= 32'(4 * (1 << AW))) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit [7:0] refRead(input bit [31:0] a);
        if (refMem.exists(a)) return refMem[a];
        return 8'h00;
    endfunction

    // Runs one request from an IDLE negedge, checks it, and returns at the next IDLE negedge.
    task automatic applyStimulus(input bit we, input bit [2:0] f3, input bit [31:0] addr,
                                 input bit [31:0] wdata, output logic [31:0] obsRdata);
        int          size;
        int          lat;
        int          weBefore;
        int          expLat;
        bit          expErr;
        logic [31:0] expRd;
        logic [3:0]  expBe;
        logic [31:0] expWd;

        size   = refSize(f3);
        expErr = refErr(we, f3, addr);
        expRd  = 32'd0;
        expBe  = 4'b0000;
        expWd  = 32'd0;
        for (int k = 0; k < size; k++) begin
            expRd = expRd | (32'(refRead(addr + 32'(k))) << (8 * k));
            expBe[(addr + 32'(k)) % 4] = 1'b1;
        end
        if (!f3[2] && size < 4 && expRd[8*size-1])
            expRd = expRd | ~((32'd1 << (8 * size)) - 32'd1);
        for (int i = 0; i < 4; i++)
            expWd[8*i +: 8] = wdata[8*(i % size) +: 8];
        if (expErr || we) expRd = 32'd0;
        expLat = expErr ? 1 : (we ? 2 : 3);

        weBefore = weCycles;
        checkOutput("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        @(negedge clk);
        // A busy unit must ignore this extra store to address 0.
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h0;
        req_wdata  = 32'hBAD0BAD0;
        if (!expErr) begin
            checkOutput("d_addr", 32'(d_addr), (addr >> 2) & 32'((1 << AW) - 1));
            checkOutput("d_we", 32'(d_we), 32'(we));
            checkOutput("d_be", 32'(d_be), we ? 32'(expBe) : 32'd0);
            if (we) checkOutput("d_wdata", d_wdata, expWd);
        end
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        req_valid = 1'b0;
        checkOutput("latency", 32'(lat), 32'(expLat));
        checkOutput("rsp_err", 32'(rsp_err), 32'(expErr));
        checkOutput("rsp_rdata", rsp_rdata, expRd);
        checkOutput("req_ready_busy", 32'(req_ready), 32'd0);
        obsRdata = rsp_rdata;
        @(negedge clk);
        checkOutput("rsp_valid_pulse", 32'(rsp_valid), 32'd0);
        checkOutput("we_cycles", 32'(weCycles - weBefore), 32'(we && !expErr));
        if (we && !expErr)
            for (int k = 0; k < size; k++) refMem[addr + 32'(k)] = wdata[8*k +: 8];
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] a;
        int          sel;

        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        repeat (2) @(negedge clk);
        checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_rsp_err", 32'(rsp_err), 32'd0);
        checkOutput("rst_rsp_rdata", rsp_rdata, 32'd0);
        checkOutput("rst_d_addr", 32'(d_addr), 32'd0);
        checkOutput("rst_d_we", 32'(d_we), 32'd0);
        checkOutput("rst_d_be", 32'(d_be), 32'd0);
        checkOutput("rst_d_wdata", d_wdata, 32'd0);

        // First request is driven together with reset release.
        reset_n = 1'b1;
        applyStimulus(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd);
        applyStimulus(1'b1, 3'b000, 32'h13, 32'h000000A5, rd);
        checkOutput("sb_ram_word", ram[4], 32'hA5ADBEEF);
        applyStimulus(1'b1, 3'b010, 32'h10, 32'h0080FF00, rd);
        applyStimulus(1'b0, 3'b000, 32'h12, 32'h0, rd);
        checkOutput("lb_const", rd, 32'hFFFFFF80);
        applyStimulus(1'b0, 3'b100, 32'h12, 32'h0, rd);
        checkOutput("lbu_const", rd, 32'h00000080);
        applyStimulus(1'b0, 3'b001, 32'h12, 32'h0, rd);
        checkOutput("lh_const", rd, 32'h00000080);
        applyStimulus(1'b0, 3'b010, 32'h6, 32'h0, rd);
        applyStimulus(1'b1, 3'b001, 32'h1, 32'h1234, rd);
        applyStimulus(1'b0, 3'b011, 32'h0, 32'h0, rd);
        applyStimulus(1'b0, 3'b010, 32'h00020000, 32'h0, rd);
        applyStimulus(1'b1, 3'b010, 32'h0001FFFC, 32'hCAFEF00D, rd);
        checkOutput("top_ram_word", ram[(1 << AW) - 1], 32'hCAFEF00D);
        applyStimulus(1'b0, 3'b010, 32'h0001FFFC, 32'h0, rd);
        checkOutput("top_load", rd, 32'hCAFEF00D);
        applyStimulus(1'b1, 3'b100, 32'h20, 32'h55, rd);

        for (int n = 0; n < 300; n++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 7)      a = 32'($urandom_range(0, 63));
            else if (sel < 9) a = 32'h1FFC0 + 32'($urandom_range(0, 127));
            else              a = $urandom;
            applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, rd);
        end

        // Reset during the ACCESS cycle of a store to an untouched word.
        a = 32'h0000_4000;
        sel = weCycles;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = a;
        req_wdata  = 32'h13572468;
        @(posedge clk);
        #2;
        req_valid = 1'b0;
        checkOutput("mid_d_we_before", 32'(d_we), 32'd1);
        reset_n = 1'b0;
        #1;
        checkOutput("mid_d_we_async", 32'(d_we), 32'd0);
        checkOutput("mid_d_be_async", 32'(d_be), 32'd0);
        checkOutput("mid_req_ready", 32'(req_ready), 32'd1);
        repeat (2) begin
            @(negedge clk);
            checkOutput("mid_rsp_valid_rst", 32'(rsp_valid), 32'd0);
        end
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
            checkOutput("post_rst_req_ready", 32'(req_ready), 32'd1);
        end
        checkOutput("mid_no_write", 32'(weCycles - sel), 32'd0);
        applyStimulus(1'b0, 3'b010, a, 32'h0, rd);
        checkOutput("mid_ram_untouched", rd, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv32i_lsu.md
RV32I_LSU -- requirements
Module: rv32i_lsu

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 15, meaning the RAM word-address width.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port req_valid, input, 1 bit: a load/store request is present.
REQ-005 SHALL have port req_ready, output, 1 bit: the unit accepts a request this cycle.
REQ-006 SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-007 SHALL have port req_funct3, input, 3 bits: RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-008 SHALL have port req_addr, input, 32 bits: byte address.
REQ-009 SHALL have port req_wdata, input, 32 bits: store data, right-aligned.
REQ-010 SHALL have port rsp_valid, output, 1 bit: one-cycle response pulse.
REQ-011 SHALL have port rsp_rdata, output, 32 bits: extended load data; 0 for stores and errors.
REQ-012 SHALL have port rsp_err, output, 1 bit: the request was rejected.
REQ-013 SHALL have port d_addr, output, ADDR_WIDTH bits: RAM word address.
REQ-014 SHALL have port d_we, output, 1 bit: RAM write enable.
REQ-015 SHALL have port d_be, output, 4 bits: RAM byte enables.
REQ-016 SHALL have port d_wdata, output, 32 bits: RAM write data, lane-replicated.
REQ-017 SHALL have port d_rdata, input, 32 bits: RAM read data, valid the cycle after d_addr is presented.

Function
REQ-018 SHALL implement states IDLE, ACCESS, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-019 SHALL accept a request on a clk edge where req_valid and req_ready are both 1, and latch we, funct3, addr and wdata.
REQ-020 SHALL flag an error on acceptance for any of these conditions: misaligned H/HU (addr[0]=1); misaligned W (addr[1:0]≠0); funct3 in {011, 110, 111}; store with funct3[2]=1; req_addr[31:ADDR_WIDTH+2]≠0.
REQ-021 SHALL transition IDLE→RESP on an accepted error request, with no RAM access, rsp_err=1 and rsp_rdata=0.
REQ-022 SHALL transition IDLE→ACCESS on an accepted valid request.
REQ-023 SHALL, in ACCESS, drive registered outputs: d_addr=addr[ADDR_WIDTH+1:2]; for a store d_we=1; for a load d_we=0 and d_be=0.
REQ-024 SHALL, for stores, drive byte enables and data as follows: SB d_be=0001<<addr[1:0] with d_wdata={4{wdata[7:0]}}; SH d_be=0011<<{addr[1],1'b0} with d_wdata={2{wdata[15:0]}}; SW d_be=1111 with d_wdata=wdata.
REQ-025 SHALL transition ACCESS→RESP for a store (rsp_err=0, rsp_rdata=0) and ACCESS→WAIT for a load.
REQ-026 SHALL, in WAIT, sample d_rdata, select the byte at lane addr[1:0] or the half at lane addr[1], and sign-extend for B/H or zero-extend for BU/HU, then go to RESP with rsp_rdata set to the result.
REQ-027 SHALL assert rsp_valid for exactly one cycle in RESP, then return to IDLE; the response has no backpressure.
REQ-028 SHALL give latency from acceptance edge to rsp_valid high: error 1 cycle, store 2 cycles, load 3 cycles.
REQ-029 SHALL hold d_we=0 and d_be=0 in every state other than ACCESS, and SHALL hold d_addr and d_wdata at their last values.
REQ-030 SHALL ignore req_valid outside IDLE; no request is queued.
REQ-031 SHALL make the maximum legal word address, 2^ADDR_WIDTH−1, accessible; the next byte address above 4·2^ADDR_WIDTH−1 SHALL error and SHALL NOT wrap.

Reset
REQ-032 SHALL, while reset_n=0, force state IDLE, req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, d_addr=0, d_we=0, d_be=0, d_wdata=0.
REQ-033 SHALL, on reset asserted mid-operation, drop d_we immediately (asynchronously), lose the in-flight request and emit no response.
REQ-034 SHALL accept the first request on the first clk edge after reset_n deasserts.

Verification
REQ-035 SHALL cover: SW addr 0x10, wdata 0xDEADBEEF -> next cycle d_addr=4, d_we=1, d_be=1111, d_wdata=0xDEADBEEF; rsp_valid 2 cycles after acceptance with rsp_err=0.
REQ-036 SHALL cover: SB addr 0x13, wdata 0x000000A5 -> d_be=1000, d_wdata=0xA5A5A5A5, d_addr=4.
REQ-037 SHALL cover: LB/LBU addr 0x12 with d_rdata=0x0080FF00 -> LB rsp_rdata=0xFFFFFF80 and LBU rsp_rdata=0x00000080, each 3 cycles after acceptance; LH addr 0x12 -> 0x00000080.
REQ-038 SHALL cover: LW addr 0x6 and SH addr 0x1 -> rsp_valid 1 cycle after acceptance with rsp_err=1, d_we never 1; funct3=011 -> rsp_err=1.
REQ-039 SHALL cover: LW addr 0x00020000 with ADDR_WIDTH=15 -> rsp_err=1; addr 0x0001FFFC -> d_addr=0x7FFF with no error.
REQ-040 SHALL cover: reset_n pulled low in ACCESS of a store -> d_we=0 without waiting for a clk edge, no rsp_valid, and req_ready=1 after release.
